// File: rtl/fft_uart_frame_sched_if.sv
// Handshake bundle between the frame scheduler, the FFT result FIFO,
// the UART transmitter and the upstream sequencer.
interface fft_uart_frame_sched_if;
    logic        start;
    logic        abort;
    logic        fifo_empty;
    logic [13:0] fifo_dout;
    logic        fifo_rd_en;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;
    logic        done;

    modport master (
        input  start, abort, fifo_empty, fifo_dout, tx_busy,
        output fifo_rd_en, tx_data, tx_start, busy, done
    );

    modport slave (
        output start, abort, fifo_empty, fifo_dout, tx_busy,
        input  fifo_rd_en, tx_data, tx_start, busy, done
    );
endinterface

// File: rtl/fft_uart_frame_sched.sv
// Drains FRAME_LEN 14-bit FFT words into a framed UART byte stream.
// Define FRAME_CHECKSUM_EN to append an XOR checksum byte to each frame.
module fft_uart_frame_sched #(
    parameter int         FRAME_LEN = 512,
    parameter logic [7:0] HEADER    = 8'hAA
) (
    input logic                     clk,
    input logic                     rst,
    fft_uart_frame_sched_if.master  bus
);
    localparam int CW = $clog2(FRAME_LEN) + 1;

    typedef enum logic [3:0] {
        IDLE, HDR, FETCH, LATCH, SEND_HI, SEND_LO,
`ifdef FRAME_CHECKSUM_EN
        CSUM,
`endif
        WAIT, FIN
    } state_t;

`ifdef FRAME_CHECKSUM_EN
    localparam state_t TERM = CSUM;
`else
    localparam state_t TERM = FIN;
`endif

    state_t        r_state, w_state;
    state_t        r_ret, w_ret;
    logic          r_skip, w_skip;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [13:0]   r_word, w_word;
    logic          r_fifo_rd_en, w_fifo_rd_en;
    logic          r_tx_start, w_tx_start;
    logic [7:0]    r_tx_data, w_tx_data;
    logic          r_busy, w_busy;
    logic          r_done, w_done;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]    r_csum, w_csum;
`endif

    logic          w_send;
    logic [7:0]    w_byte;
    state_t        w_succ;
    logic [CW-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state      = r_state;
        w_ret        = r_ret;
        w_skip       = r_skip;
        w_cnt        = r_cnt;
        w_word       = r_word;
        w_fifo_rd_en = 1'b0;
        w_tx_start   = 1'b0;
        w_tx_data    = r_tx_data;
        w_busy       = r_busy;
        w_done       = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        w_csum       = r_csum;
`endif
        w_send       = 1'b0;
        w_byte       = 8'h00;
        w_succ       = FETCH;

        if (bus.abort) begin
            w_state = IDLE;
            w_busy  = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        w_state = HDR;
                        w_cnt   = '0;
                        w_busy  = 1'b1;
`ifdef FRAME_CHECKSUM_EN
                        w_csum  = 8'h00;
`endif
                    end
                end
                HDR: begin
                    w_send = 1'b1;
                    w_byte = HEADER;
                    w_succ = FETCH;
                end
                FETCH: begin
                    if (!bus.fifo_empty) begin
                        w_fifo_rd_en = 1'b1;
                        w_state      = LATCH;
                    end
                end
                // First LATCH cycle is the read strobe itself; data lands one cycle later.
                LATCH: begin
                    if (!r_fifo_rd_en) begin
                        w_word  = bus.fifo_dout;
                        w_state = SEND_HI;
                    end
                end
                SEND_HI: begin
                    w_send = 1'b1;
                    w_byte = {2'b00, r_word[13:8]};
                    w_succ = SEND_LO;
                end
                SEND_LO: begin
                    w_send = 1'b1;
                    w_byte = r_word[7:0];
                    w_succ = (w_cnt_inc == CW'(FRAME_LEN)) ? TERM : FETCH;
                end
`ifdef FRAME_CHECKSUM_EN
                CSUM: begin
                    w_send = 1'b1;
                    w_byte = r_csum;
                    w_succ = FIN;
                end
`endif
                // Done/busy are staged on the way into FIN so they land as FIN's outputs.
                WAIT: begin
                    if (r_skip) begin
                        w_skip = 1'b0;
                    end else if (!bus.tx_busy) begin
                        w_state = r_ret;
                        if (r_ret == FIN) begin
                            w_done = 1'b1;
                            w_busy = 1'b0;
                        end
                    end
                end
                FIN: w_state = IDLE;
                default: w_state = IDLE;
            endcase

            if (w_send && !bus.tx_busy) begin
                w_tx_start = 1'b1;
                w_tx_data  = w_byte;
                w_ret      = w_succ;
                w_skip     = 1'b1;
                w_state    = WAIT;
                if (r_state == SEND_LO) w_cnt = w_cnt_inc;
`ifdef FRAME_CHECKSUM_EN
                if (r_state == SEND_HI || r_state == SEND_LO)
                    w_csum = r_csum ^ w_byte;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ret        <= IDLE;
            r_skip       <= 1'b0;
            r_cnt        <= '0;
            r_word       <= '0;
            r_fifo_rd_en <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            r_csum       <= 8'h00;
`endif
        end else begin
            r_state      <= w_state;
            r_ret        <= w_ret;
            r_skip       <= w_skip;
            r_cnt        <= w_cnt;
            r_word       <= w_word;
            r_fifo_rd_en <= w_fifo_rd_en;
            r_tx_start   <= w_tx_start;
            r_tx_data    <= w_tx_data;
            r_busy       <= w_busy;
            r_done       <= w_done;
`ifdef FRAME_CHECKSUM_EN
            r_csum       <= w_csum;
`endif
        end
    end

    assign bus.fifo_rd_en = r_fifo_rd_en;
    assign bus.tx_start   = r_tx_start;
    assign bus.tx_data    = r_tx_data;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_fft_uart_frame_sched.sv
// Scoreboard bench for fft_uart_frame_sched with FRAME_LEN=4,
// a behavioural FIFO and a UART that stays busy 10 cycles per byte.
module tb_fft_uart_frame_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fft_uart_frame_sched_if bus ();

    fft_uart_frame_sched #(.FRAME_LEN(4), .HEADER(8'hAA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_bytes = 0;
    int n_rd = 0;
    int n_done = 0;
    logic [7:0] exp_q[$];

`ifdef FRAME_CHECKSUM_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    // FIFO model: data appears the cycle after the read strobe.
    logic [13:0] fifo_mem [0:31];
    logic [4:0]  wp = '0;
    logic [4:0]  rp = '0;
    logic [13:0] fdout = '0;
    assign bus.fifo_empty = (wp == rp);
    assign bus.fifo_dout  = fdout;
    always @(posedge clk) begin
        if (bus.fifo_rd_en && wp != rp) begin
            fdout <= fifo_mem[rp];
            rp    <= rp + 5'd1;
        end
    end

    // UART model: busy rises the cycle after tx_start for 10 cycles.
    int uart_cnt = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) uart_cnt <= 0;
        else if (bus.tx_start) uart_cnt <= 10;
        else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
    end
    assign bus.tx_busy = (uart_cnt != 0);

    // Monitor: pops the scoreboard on every byte and checks done.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_start) begin
                n_bytes++;
                checks++;
                if (bus.tx_busy) begin
                    failures++;
                    $display("FAIL start_while_busy data=%02h", bus.tx_data);
                end else if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte got=%02h", bus.tx_data);
                end else begin
                    automatic logic [7:0] e = exp_q.pop_front();
                    if (bus.tx_data !== e) begin
                        failures++;
                        $display("FAIL byte%0d got=%02h exp=%02h",
                                 n_bytes, bus.tx_data, e);
                    end
                end
            end
            if (bus.fifo_rd_en) n_rd++;
            if (bus.done) begin
                n_done++;
                checks++;
                if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL done_early left=%0d busy=%0b",
                             exp_q.size(), bus.busy);
                end
            end
        end
    end

    logic [7:0] v1 [10] = '{8'hAA, 8'h3F, 8'hFF, 8'h00, 8'h01,
                            8'h12, 8'h34, 8'h2A, 8'h55, 8'h98};
    logic [7:0] v2 [10] = '{8'hAA, 8'h00, 8'h01, 8'h12, 8'h34,
                            8'h2A, 8'h55, 8'h0A, 8'hBC, 8'hEE};

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic push(input logic [13:0] w);
        fifo_mem[wp] = w;
        wp = wp + 5'd1;
    endtask

    task automatic push4();
        push(14'h3FFF);
        push(14'h0001);
        push(14'h1234);
        push(14'h2A55);
    endtask

    task automatic exp_v1();
        for (int i = 0; i < NB; i++) exp_q.push_back(v1[i]);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        automatic int d0 = n_done;
        automatic int i = 0;
        while (n_done == d0 && i < 1000) begin
            cyc(1);
            i++;
        end
        cyc(1);
        chk(nm, n_done - d0, 1);
    endtask

    task automatic wait_bytes(input int n, input string nm);
        automatic int i = 0;
        while (n_bytes < n && i < 1000) begin
            cyc(1);
            i++;
        end
        chk(nm, (n_bytes >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_txbusy(input logic v);
        automatic int i = 0;
        while (bus.tx_busy !== v && i < 100) begin
            cyc(1);
            i++;
        end
        chk("tx_busy_wait", bus.tx_busy, v);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_rd_en"}, bus.fifo_rd_en, 0);
        chk({nm, "_tx_start"}, bus.tx_start, 0);
        chk({nm, "_tx_data"}, bus.tx_data, 8'h00);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_done"}, bus.done, 0);
    endtask

    initial begin
        int b0, r0, d0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        cyc(2);
        chk_reset("reset");
        rst = 1'b0;
        cyc(2);

        // Full frame with start-to-header latency check.
        push4();
        exp_v1();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        chk("no_early_tx", bus.tx_start, 0);
        cyc(1);
        chk("hdr_tx_start", bus.tx_start, 1);
        chk("hdr_tx_data", bus.tx_data, 8'hAA);
        cyc(30);
        pulse_start();
        wait_done("frame1_done");
        chk("frame1_rd", n_rd, 4);
        chk("frame1_bytes", n_bytes, NB);
        chk("done_one_cycle", bus.done, 0);
        chk("busy_after_done", bus.busy, 0);

        // FIFO runs dry after two words, refilled 50 cycles later.
        b0 = n_bytes;
        r0 = n_rd;
        push(14'h3FFF);
        push(14'h0001);
        exp_v1();
        pulse_start();
        wait_bytes(b0 + 5, "stall_reach");
        cyc(20);
        pulse_start();
        cyc(30);
        chk("stall_bytes", n_bytes - b0, 5);
        chk("stall_rd", n_rd - r0, 2);
        chk("stall_busy", bus.busy, 1);
        push(14'h1234);
        push(14'h2A55);
        wait_done("stall_done");
        chk("stall_rd_total", n_rd - r0, 4);

        // Abort during the third byte's WAIT.
        b0 = n_bytes;
        r0 = n_rd;
        d0 = n_done;
        push4();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h3F);
        exp_q.push_back(8'hFF);
        pulse_start();
        wait_bytes(b0 + 3, "abort_reach");
        cyc(2);
        bus.abort = 1'b1;
        cyc(1);
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_tx_start", bus.tx_start, 0);
        chk("abort_rd_en", bus.fifo_rd_en, 0);
        cyc(40);
        chk("abort_bytes", n_bytes - b0, 3);
        chk("abort_rd", n_rd - r0, 1);
        chk("abort_no_done", n_done - d0, 0);

        // Remaining FIFO words are kept; fresh header follows.
        push(14'h0ABC);
        for (int i = 0; i < NB; i++) exp_q.push_back(v2[i]);
        pulse_start();
        wait_done("post_abort_done");

        // start with abort in IDLE is ignored.
        b0 = n_bytes;
        r0 = n_rd;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("sa_busy", bus.busy, 0);
        cyc(30);
        chk("sa_bytes", n_bytes - b0, 0);
        chk("sa_rd", n_rd - r0, 0);

        // Async reset while SEND_LO of the first word is pending.
        b0 = n_bytes;
        d0 = n_done;
        push4();
        exp_v1();
        pulse_start();
        wait_bytes(b0 + 2, "rst_reach");
        wait_txbusy(1'b1);
        wait_txbusy(1'b0);
        cyc(1);
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        exp_q.delete();
        wp = rp;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        chk("rst_no_done", n_done - d0, 0);
        chk("rst_bytes", n_bytes - b0, 2);

        b0 = n_bytes;
        push4();
        exp_v1();
        pulse_start();
        wait_done("post_rst_done");
        chk("post_rst_bytes", n_bytes - b0, NB);
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
